// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared speed types and clock-generator defaults
package vector_pkg;

  // Speed set of the Vector 06C CPU: 3, 6 and 12 MHz
  localparam int NSPEED_DEF = 3;
  localparam int SPEED_W    = $clog2(NSPEED_DEF);

  typedef logic [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_3M  = speed_t'(0);
  localparam speed_t SPEED_6M  = speed_t'(1);
  localparam speed_t SPEED_12M = speed_t'(2);

  // 96 MHz / 55 ~ 1.75 MHz for the PSG, div bit 5 gives 1.5 MHz for the PIT
  localparam int PSG_DIV_DEF = 55;
  localparam int PIT_BIT_DEF = 5;

endpackage

// File: rtl/ce_div.sv
// rtl/ce_div.sv - modulo-N counter emitting a one-cycle enable at count 0
module ce_div #(
  parameter int N = 55
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ce_o
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ce_q, ce_d;

  // Count 0..N-1 and flag the zero state one cycle later
  always_comb begin
    ce_d  = (cnt_q == '0);
    cnt_d = cnt_q + W'(1);
    if (cnt_q == W'(N - 1)) begin
      cnt_d = '0;
    end
  end

  // Counter and pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/bus_clkgen.sv
// rtl/bus_clkgen.sv - CPU/video/PSG/PIT clock enables and memory wait states
module bus_clkgen
  import vector_pkg::*;
#(
  parameter int                DIV_W       = 7,
  parameter int                BASE_PERIOD = 32,
  parameter int                NSPEED      = 3,
  parameter logic [NSPEED-1:0] WAIT_MASK   = NSPEED'(1),
  parameter int                PSG_DIV     = PSG_DIV_DEF,
  parameter int                PIT_BIT     = PIT_BIT_DEF
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [$clog2(NSPEED)-1:0] speed_req,
  input  logic                      cpu_sync,
  input  logic                      mreq,
  output logic [$clog2(NSPEED)-1:0] speed_cur,
  output logic                      ce_f1,
  output logic                      ce_f2,
  output logic                      ce_12mp,
  output logic                      ce_12mn,
  output logic                      ce_psg,
  output logic                      clk_pit,
  output logic                      cpu_ready
);

  localparam int SW = $clog2(NSPEED);

  logic [DIV_W-1:0] div_q, div_d;
  logic [SW-1:0]    speed_q, speed_d;
  logic             f1_q, f1_d, f2_q, f2_d;
  logic             p12_q, p12_d, n12_q, n12_d;
  logic             pit_q, pit_d, rdy_q, rdy_d;

  logic [DIV_W-1:0] mask, half, quarter, m;
  logic             wait_en, at_mid, stall;

  // Phase position inside the CPU period of the speed currently in effect
  always_comb begin
    mask    = DIV_W'((BASE_PERIOD >> speed_q) - 1);
    half    = DIV_W'((BASE_PERIOD >> speed_q) >> 1);
    quarter = DIV_W'((BASE_PERIOD >> speed_q) >> 2);
    m       = div_q & mask;
    wait_en = WAIT_MASK[speed_q];
    at_mid  = (div_q[DIV_W-1 -: 3] == 3'b100);
    stall   = cpu_sync & mreq & (m < quarter);
  end

  // Next divider, speed, enables and READY from the current divider value
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    speed_d = speed_q;
    // Speed changes land only on the window wrap so periods never tear
    if ((&div_q) && (int'(speed_req) < NSPEED)) begin
      speed_d = speed_req;
    end

    f1_d  = (m == '0);
    f2_d  = (m == half);
    p12_d = (div_q[2:0] == 3'd0);
    n12_d = (div_q[2:0] == 3'd4);
    pit_d = div_q[PIT_BIT];

    // Release at the window midpoint beats a coincident stall request
    rdy_d = rdy_q;
    if (!wait_en) begin
      rdy_d = 1'b1;
    end else if (at_mid) begin
      rdy_d = 1'b1;
    end else if (stall) begin
      rdy_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      speed_q <= SW'(SPEED_3M);
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      p12_q   <= 1'b0;
      n12_q   <= 1'b0;
      pit_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      p12_q   <= p12_d;
      n12_q   <= n12_d;
      pit_q   <= pit_d;
      rdy_q   <= rdy_d;
    end
  end

  ce_div #(
    .N(PSG_DIV)
  ) u_psg_div (
    .clk_i (clk_sys),
    .rst_ni(reset_n),
    .ce_o  (ce_psg)
  );

  assign speed_cur = speed_q;
  assign ce_f1     = f1_q;
  assign ce_f2     = f2_q;
  assign ce_12mp   = p12_q;
  assign ce_12mn   = n12_q;
  assign clk_pit   = pit_q;
  assign cpu_ready = rdy_q;

endmodule

// File: tb/tb_bus_clkgen.sv
// tb/tb_bus_clkgen.sv - self-checking bench for bus_clkgen
module tb_bus_clkgen;

  localparam int WIN  = 128;
  localparam int BASE = 32;
  localparam int NV   = 10;
  localparam logic [2:0] WMASK = 3'b001;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] speed_req = 2'd0;
  logic       cpu_sync = 1'b0;
  logic       mreq = 1'b0;
  logic [1:0] speed_cur;
  logic       ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit, cpu_ready;

  bus_clkgen dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .speed_req(speed_req),
    .cpu_sync (cpu_sync),
    .mreq     (mreq),
    .speed_cur(speed_cur),
    .ce_f1    (ce_f1),
    .ce_f2    (ce_f2),
    .ce_12mp  (ce_12mp),
    .ce_12mn  (ce_12mn),
    .ce_psg   (ce_psg),
    .clk_pit  (clk_pit),
    .cpu_ready(cpu_ready)
  );

  always #5 clk_sys = ~clk_sys;

  int ncheck = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: absolute time since reset, per-window speed, READY flag
  int         t_m;
  logic [1:0] spd_m;
  logic       rdy_m;

  task automatic model_edge(output logic [8:0] e);
    int d, p;
    logic [1:0] nxt;
    d = t_m % WIN;
    p = BASE >> spd_m;
    if (!WMASK[spd_m]) rdy_m = 1'b1;
    else if (d >= WIN / 2 && d < WIN / 2 + WIN / 8) rdy_m = 1'b1;
    else if (cpu_sync && mreq && (d % p) < p / 4) rdy_m = 1'b0;
    nxt = (d == WIN - 1 && speed_req < 2'd3) ? speed_req : spd_m;
    e = {nxt, (d % p == 0), (d % p == p / 2), (d % 8 == 0), (d % 8 == 4),
         (t_m % 55 == 0), ((d / 32) % 2 == 1), rdy_m};
    spd_m = nxt;
    t_m++;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cpu_sync  = 1'b0;
    mreq      = 1'b0;
    speed_req = 2'd0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    t_m   = 0;
    spd_m = 2'd0;
    rdy_m = 1'b1;
  endtask

  typedef struct {
    string name;
    int    req;
    int    req_at;
    int    pulse_at;
    int    edges;
    int    exp_f1;
    int    exp_low;
    int    exp_speed;
  } vec_t;

  vec_t vecs[NV];

  int         nf1, nlow, f1_at, f2_at;
  int         npsg, last_psg, psg_gmin, psg_gmax;
  int         n12p, n12n, last_12p, bad_off;
  int         pit_hi, last_rise, pit_gmin, pit_gmax;
  logic       pit_prev;
  logic [8:0] exp_v;

  initial begin
    //           name           req at   pulse edges f1 low spd
    vecs[0] = '{"idle",         0, 0,   -1,   256,  8,  0, 0};
    vecs[1] = '{"to_12m",       2, 37,  -1,   256, 20,  0, 2};
    vecs[2] = '{"illegal",      3, 0,   -1,   512, 16,  0, 0};
    vecs[3] = '{"stall_m3",     0, 0,    3,   256,  8, 61, 0};
    vecs[4] = '{"nostall_m8",   0, 0,    8,   256,  8,  0, 0};
    vecs[5] = '{"stall_m7",     0, 0,    7,   256,  8, 57, 0};
    vecs[6] = '{"spd1_nowait",  1, 0,  131,   256, 12,  0, 1};
    vecs[7] = '{"collision",    0, 0,   64,   256,  8,  0, 0};
    vecs[8] = '{"forced_rel",   1, 101, 100,  256, 12, 28, 1};
    vecs[9] = '{"stall_win1",   0, 0,  163,   256,  8, 29, 0};

    // Reset asserted mid-count, then first-cycle pulses and phase spacing
    do_reset();
    repeat (45) @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check("async_reset", {speed_cur, ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit, cpu_ready},
             9'b00_000000_1);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("first_cycle", {ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit, cpu_ready}, 7'b1010101);
    f1_at = -1;
    f2_at = -1;
    for (int t = 1; t < 64; t++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (ce_f2 && f2_at < 0) f2_at = t;
      if (ce_f1 && f1_at < 0) f1_at = t;
    end
    check("first_f2", f2_at, 16);
    check("second_f1", f1_at, 32);

    // Table-driven scenarios from reset
    for (int i = 0; i < NV; i++) begin
      do_reset();
      nf1  = 0;
      nlow = 0;
      for (int t = 0; t < vecs[i].edges; t++) begin
        speed_req = (t >= vecs[i].req_at) ? 2'(vecs[i].req) : 2'd0;
        cpu_sync  = (t == vecs[i].pulse_at);
        mreq      = cpu_sync;
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (ce_f1) nf1++;
        if (!cpu_ready) nlow++;
      end
      cpu_sync = 1'b0;
      mreq     = 1'b0;
      check({vecs[i].name, "_f1"}, nf1, vecs[i].exp_f1);
      check({vecs[i].name, "_low"}, nlow, vecs[i].exp_low);
      check({vecs[i].name, "_speed"}, speed_cur, vecs[i].exp_speed);
    end

    // Fixed dividers over 5500 cycles
    do_reset();
    npsg = 0; last_psg = -1; psg_gmin = 1000000; psg_gmax = 0;
    n12p = 0; n12n = 0; last_12p = -100; bad_off = 0;
    pit_hi = 0; last_rise = -1; pit_gmin = 1000000; pit_gmax = 0; pit_prev = 1'b0;
    for (int t = 0; t < 5500; t++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (ce_psg) begin
        npsg++;
        if (last_psg >= 0) begin
          if (t - last_psg < psg_gmin) psg_gmin = t - last_psg;
          if (t - last_psg > psg_gmax) psg_gmax = t - last_psg;
        end
        last_psg = t;
      end
      if (ce_12mp) begin
        n12p++;
        last_12p = t;
      end
      if (ce_12mn) begin
        n12n++;
        if (t - last_12p != 4) bad_off++;
      end
      if (clk_pit) pit_hi++;
      if (clk_pit && !pit_prev) begin
        if (last_rise >= 0) begin
          if (t - last_rise < pit_gmin) pit_gmin = t - last_rise;
          if (t - last_rise > pit_gmax) pit_gmax = t - last_rise;
        end
        last_rise = t;
      end
      pit_prev = clk_pit;
    end
    check("psg_count", npsg, 100);
    check("psg_gap_min", psg_gmin, 55);
    check("psg_gap_max", psg_gmax, 55);
    check("ce12p_count", n12p, 688);
    check("ce12n_count", n12n, 687);
    check("ce12n_offset", bad_off, 0);
    check("pit_high", pit_hi, 2748);
    check("pit_gap_min", pit_gmin, 64);
    check("pit_gap_max", pit_gmax, 64);

    // Randomised traffic against the reference model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 31) == 0) speed_req = 2'($urandom_range(0, 3));
      cpu_sync = ($urandom_range(0, 3) == 0);
      mreq     = 1'($urandom_range(0, 1));
      model_edge(exp_v);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("rand_outputs",
            {speed_cur, ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit, cpu_ready}, exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
